// File: rtl/pipelined_addsub_if.sv
// Handshake bundle for pipelined_addsub: an operand stream (a, b, sub,
// carryin under in_valid/in_ready) and a result stream (res, carryout,
// overflow under out_valid/out_ready).
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             carryin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             carryout;
    logic             overflow;

    // Operand source and result sink side
    modport master (
        output in_valid, a, b, sub, carryin, out_ready,
        input  in_ready, out_valid, res, carryout, overflow
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, sub, carryin, out_ready,
        output in_ready, out_valid, res, carryout, overflow
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor.
//
// The WIDTH-bit carry chain is cut into STAGES chunks of CW = WIDTH/STAGES
// bits; stage k adds chunk k using the carry registered by stage k-1 (stage 0
// uses carryin). The whole pipeline advances together whenever the output
// register is empty or being consumed, so a stall freezes every stage.
//
// Operand a travels as a rotating word: each stage shifts the unconsumed a
// bits down by CW and drops its finished result chunk in at the top, so after
// the last stage the word is exactly the result. The inverted-or-not b
// operand shrinks by CW bits per stage and is not stored in the last stage.
//
// Optional feature macro: ADDSUB_SAT_EN. When defined, a result with signed
// overflow is replaced by the signed saturation value (0111..1 for positive
// overflow, 1000..0 for negative); overflow and carryout are still reported
// as computed. When undefined, res wraps modulo 2^WIDTH.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    pipelined_addsub_if.slave io
);
    localparam int CW = WIDTH / STAGES;

    // Whole pipeline moves when the output slot is free or being drained.
    logic advance;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Width of the b bits still to be consumed entering this stage.
            localparam int BW = WIDTH - gi * CW;

            logic             v_q;     // stage holds a live operation
            logic [WIDTH-1:0] a_q;     // {finished result chunks, unconsumed a bits}
            logic             c_q;     // carry out of this stage's chunk

            logic             v_in;
            logic [WIDTH-1:0] a_in;
            logic [BW-1:0]    b_in;
            logic             c_in;
            logic [CW:0]      sum;
            logic [WIDTH-1:0] a_d;

            if (gi == 0) begin : g_src
                assign v_in = io.in_valid;
                assign a_in = io.a;
                assign b_in = io.b ^ {WIDTH{io.sub}};
                assign c_in = io.carryin;
            end else begin : g_src
                assign v_in = g_stage[gi-1].v_q;
                assign a_in = g_stage[gi-1].a_q;
                assign b_in = g_stage[gi-1].g_mid.b_q;
                assign c_in = g_stage[gi-1].c_q;
            end

            // Chunk adder: one extra bit catches the carry for the next stage.
            assign sum = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

            // Rotate: drop the consumed a chunk, insert the result chunk on top.
            assign a_d = (a_in >> CW) | (WIDTH'(sum[CW-1:0]) << (WIDTH - CW));

            if (gi < STAGES - 1) begin : g_mid
                logic [BW-CW-1:0] b_q;  // b bits not yet added

                // Hand the partial result, remaining b bits and chunk carry onward.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        v_q <= 1'b0;
                        a_q <= '0;
                        b_q <= '0;
                        c_q <= 1'b0;
                    end else if (advance) begin
                        v_q <= v_in;
                        a_q <= a_d;
                        b_q <= b_in[BW-1:CW];
                        c_q <= sum[CW];
                    end
                end
            end else begin : g_last
                logic             ovf_q;
                logic             msb_cin;  // carry into bit WIDTH-1
                logic             ovf_d;
                logic [WIDTH-1:0] res_d;

                // The top bit of this chunk is bit WIDTH-1 of the full word;
                // its incoming carry is recovered from the sum bit.
                assign msb_cin = a_in[CW-1] ^ b_in[CW-1] ^ sum[CW-1];
                assign ovf_d   = msb_cin ^ sum[CW];

`ifdef ADDSUB_SAT_EN
                logic [WIDTH-1:0] sat_neg;
                logic [WIDTH-1:0] sat_pos;
                assign sat_neg = WIDTH'(1) << (WIDTH - 1);
                assign sat_pos = ~sat_neg;
                // On overflow both operands share a's sign, which picks the rail.
                assign res_d = !ovf_d ? a_d : (a_in[CW-1] ? sat_neg : sat_pos);
`else
                assign res_d = a_d;
`endif

                // Output register: updates only on advance, so it is frozen
                // while a result waits for the consumer.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        v_q   <= 1'b0;
                        a_q   <= '0;
                        c_q   <= 1'b0;
                        ovf_q <= 1'b0;
                    end else if (advance) begin
                        v_q   <= v_in;
                        a_q   <= res_d;
                        c_q   <= sum[CW];
                        ovf_q <= ovf_d;
                    end
                end
            end
        end
    endgenerate

    assign advance      = !g_stage[STAGES-1].v_q || io.out_ready;
    assign io.in_ready  = advance;
    assign io.out_valid = g_stage[STAGES-1].v_q;
    assign io.res       = g_stage[STAGES-1].a_q;
    assign io.carryout  = g_stage[STAGES-1].c_q;
    assign io.overflow  = g_stage[STAGES-1].g_last.ovf_q;
endmodule
